// File: rtl/dec_scan_pkg.sv
// rtl/dec_scan_pkg.sv - shared types and constants for the decoder fault scanner
package dec_scan_pkg;

    localparam int SEL_W   = 4;
    localparam int OUT_W   = 16;
    localparam int N_CODES = 2 ** SEL_W;
    localparam int CNT_W   = $clog2(N_CODES + 1);

    localparam logic [SEL_W-1:0] LAST_CODE = 4'hF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } scan_state_e;

    typedef struct packed {
        logic [OUT_W-1:0] fail_map;
        logic [CNT_W-1:0] fail_cnt;
        logic [SEL_W-1:0] first_fail_code;
        logic             first_fail_vld;
    } scan_result_t;

endpackage

// File: rtl/dec_fault_scanner_if.sv
// rtl/dec_fault_scanner_if.sv - scan control, decoder stimulus/response and result bus (DEC_SCAN_SYNDROME_EN adds syndrome)
interface dec_fault_scanner_if;
    import dec_scan_pkg::*;

    logic                start;
    logic                abort;
    logic [OUT_W-1:0]    dut_d;
    logic [SEL_W-1:0]    sel;
    logic                busy;
    logic                done;
    logic                pass;
    logic [CNT_W-1:0]    fail_cnt;
    logic [OUT_W-1:0]    fail_map;
    logic [SEL_W-1:0]    first_fail_code;
    logic                first_fail_vld;
`ifdef DEC_SCAN_SYNDROME_EN
    logic [OUT_W-1:0]    syndrome;
`endif

    modport master (
        output start, abort, dut_d,
        input  sel, busy, done, pass, fail_cnt, fail_map, first_fail_code, first_fail_vld
`ifdef DEC_SCAN_SYNDROME_EN
        , input syndrome
`endif
    );

    modport slave (
        input  start, abort, dut_d,
        output sel, busy, done, pass, fail_cnt, fail_map, first_fail_code, first_fail_vld
`ifdef DEC_SCAN_SYNDROME_EN
        , output syndrome
`endif
    );

endinterface

// File: rtl/dec_onehot_ref.sv
// rtl/dec_onehot_ref.sv - golden 4-to-16 one-hot decoder used as the expected response
module dec_onehot_ref
    import dec_scan_pkg::*;
(
    input  logic [SEL_W-1:0] sel,
    output logic [OUT_W-1:0] onehot
);

    assign onehot = {{(OUT_W-1){1'b0}}, 1'b1} << sel;

endmodule

// File: rtl/dec_fault_scanner.sv
// rtl/dec_fault_scanner.sv - sweeps all select codes into a decoder under test and logs mismatches
// Optional syndrome capture of the first mismatch is built when DEC_SCAN_SYNDROME_EN is defined.
module dec_fault_scanner
    import dec_scan_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    dec_fault_scanner_if.slave    bus
);

    localparam logic [1:0] ST_IDLE   = IDLE;
    localparam logic [1:0] ST_SETTLE = SETTLE;
    localparam logic [1:0] ST_SAMPLE = SAMPLE;
    localparam logic [1:0] ST_DONE   = DONE;

    localparam int SCNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SCNT_W-1:0] SETTLE_RELOAD = SCNT_W'(SETTLE_CYCLES - 1);

    logic [1:0]         state;
    logic [SEL_W-1:0]   sel_q;
    logic [SCNT_W-1:0]  settle_cnt;
    scan_result_t       res;
    logic [OUT_W-1:0]   exp_d;
    logic               mismatch;
    logic               sample_fail;

    dec_onehot_ref u_ref (
        .sel    (sel_q),
        .onehot (exp_d)
    );

    // Any pattern other than the exact one-hot word counts, including all-zero and multi-hot.
    assign mismatch    = (bus.dut_d != exp_d);
    assign sample_fail = (state == ST_SAMPLE) && mismatch;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            sel_q      <= '0;
            settle_cnt <= '0;
            res        <= '0;
        end else if (bus.abort) begin
            state      <= ST_IDLE;
            sel_q      <= '0;
            settle_cnt <= '0;
            res        <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        state      <= ST_SETTLE;
                        sel_q      <= '0;
                        settle_cnt <= SETTLE_RELOAD;
                        res        <= '0;
                    end
                end
                ST_SETTLE: begin
                    if (settle_cnt == '0) begin
                        state <= ST_SAMPLE;
                    end else begin
                        settle_cnt <= settle_cnt - 1'b1;
                    end
                end
                ST_SAMPLE: begin
                    if (mismatch) begin
                        res.fail_map[sel_q] <= 1'b1;
                        res.fail_cnt        <= res.fail_cnt + 1'b1;
                        if (!res.first_fail_vld) begin
                            res.first_fail_code <= sel_q;
                            res.first_fail_vld  <= 1'b1;
                        end
                    end
                    // sel parks on the last code in DONE rather than wrapping to zero.
                    if (sel_q == LAST_CODE) begin
                        state <= ST_DONE;
                    end else begin
                        sel_q      <= sel_q + 1'b1;
                        settle_cnt <= SETTLE_RELOAD;
                        state      <= ST_SETTLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef DEC_SCAN_SYNDROME_EN
    logic [OUT_W-1:0] syndrome_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            syndrome_q <= '0;
        end else if (bus.abort) begin
            syndrome_q <= '0;
        end else if ((state == ST_IDLE || state == ST_DONE) && bus.start) begin
            syndrome_q <= '0;
        end else if (sample_fail && !res.first_fail_vld) begin
            syndrome_q <= bus.dut_d ^ exp_d;
        end
    end

    assign bus.syndrome = syndrome_q;
`endif

    assign bus.sel             = sel_q;
    assign bus.busy            = (state == ST_SETTLE) || (state == ST_SAMPLE);
    assign bus.done            = (state == ST_DONE);
    assign bus.pass            = (state == ST_DONE) && (res.fail_cnt == '0);
    assign bus.fail_cnt        = res.fail_cnt;
    assign bus.fail_map        = res.fail_map;
    assign bus.first_fail_code = res.first_fail_code;
    assign bus.first_fail_vld  = res.first_fail_vld;

endmodule

// File: tb/tb_dec_fault_scanner.sv
// tb/tb_dec_fault_scanner.sv - randomized self-checking bench for dec_fault_scanner against a scan-level model
module tb_dec_fault_scanner;
    import dec_scan_pkg::*;

    localparam int SETTLE = 1;
    localparam int SCAN_LEN = 16 * (SETTLE + 1);

    logic clk;
    logic rst_n;
    int   fault;
    logic [15:0] rnd_tab [16];

    int checks;
    int failures;
    bit cmp_en;

    // Scan-level model: mode 0 idle, 1 scanning (n edges since accept), 2 done.
    int m_mode;
    int m_n;
    int m_fault;

    dec_fault_scanner_if bus ();

    dec_fault_scanner #(.SETTLE_CYCLES(SETTLE)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic logic [15:0] dut_of(input int s, input int f);
        logic [15:0] good;
        good = 16'h1 << s;
        case (f)
            1:       return (s >= 8) ? 16'h0000 : good;
            2:       return good | 16'h0008;
            3:       return 16'h1 << (s ^ 1);
            4:       return rnd_tab[s];
            default: return good;
        endcase
    endfunction

    assign bus.dut_d = dut_of(int'(bus.sel), fault);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode <= 0;
            m_n    <= 0;
        end else if (bus.abort) begin
            m_mode <= 0;
            m_n    <= 0;
        end else if (bus.start && m_mode != 1) begin
            m_mode  <= 1;
            m_n     <= 0;
            m_fault <= fault;
        end else if (m_mode == 1) begin
            m_n <= m_n + 1;
            if (m_n + 1 == SCAN_LEN) m_mode <= 2;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, req, $time);
        end
    endtask

    task automatic check_model();
        int          ncodes;
        int          e_sel;
        logic [15:0] e_map;
        int          e_cnt;
        int          e_first;
        bit          e_vld;
        logic [15:0] e_syn;
        logic [15:0] d;
        ncodes = (m_mode == 2) ? 16 : (m_mode == 1) ? m_n / (SETTLE + 1) : 0;
        e_sel  = (m_mode == 2) ? 15 : (m_mode == 1) ? m_n / (SETTLE + 1) : 0;
        e_map = '0; e_cnt = 0; e_first = 0; e_vld = 0; e_syn = '0;
        for (int k = 0; k < ncodes; k++) begin
            d = dut_of(k, m_fault);
            if (d != (16'h1 << k)) begin
                e_map[k] = 1'b1;
                e_cnt++;
                if (!e_vld) begin
                    e_vld   = 1'b1;
                    e_first = k;
                    e_syn   = d ^ (16'h1 << k);
                end
            end
        end
        chk("sel",      32'(bus.sel),             32'(e_sel));
        chk("busy",     32'(bus.busy),            32'(m_mode == 1));
        chk("done",     32'(bus.done),            32'(m_mode == 2));
        chk("pass",     32'(bus.pass),            32'(m_mode == 2 && e_cnt == 0));
        chk("fail_cnt", 32'(bus.fail_cnt),        32'(e_cnt));
        chk("fail_map", 32'(bus.fail_map),        32'(e_map));
        chk("first",    32'(bus.first_fail_code), 32'(e_first));
        chk("vld",      32'(bus.first_fail_vld),  32'(e_vld));
`ifdef DEC_SCAN_SYNDROME_EN
        chk("syndrome", 32'(bus.syndrome),        32'(e_syn));
`endif
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!bus.done && cyc < 200) begin
            step();
            cyc++;
        end
        if (!bus.done) begin
            failures++;
            $display("FAIL done_timeout actual=%0d required=%0d", cyc, SCAN_LEN);
        end
    endtask

    task automatic run_scan(input int f, output int cyc);
        fault     = f;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        wait_done(cyc);
    endtask

    initial begin
        int cyc;
        checks = 0; failures = 0; cmp_en = 0;
        rst_n = 1'b0; fault = 0; bus.start = 1'b0; bus.abort = 1'b0;
        m_fault = 0;
        for (int k = 0; k < 16; k++) rnd_tab[k] = 16'h1 << k;
        fork
            begin
                step(); step();
                chk("rst_sel",  32'(bus.sel), 0);
                chk("rst_busy", 32'(bus.busy), 0);
                chk("rst_done", 32'(bus.done), 0);
                chk("rst_pass", 32'(bus.pass), 0);
                chk("rst_map",  32'(bus.fail_map), 0);
                chk("rst_vld",  32'(bus.first_fail_vld), 0);
                rst_n  = 1'b1;
                cmp_en = 1'b1;
                step();

                run_scan(0, cyc);
                chk("t1_latency", 32'(cyc), 32);
                chk("t1_pass", 32'(bus.pass), 1);
                chk("t1_cnt",  32'(bus.fail_cnt), 0);
                chk("t1_map",  32'(bus.fail_map), 32'h0000);

                run_scan(1, cyc);
                chk("t2_cnt",   32'(bus.fail_cnt), 8);
                chk("t2_map",   32'(bus.fail_map), 32'hFF00);
                chk("t2_first", 32'(bus.first_fail_code), 8);

                run_scan(2, cyc);
                chk("t3_cnt",   32'(bus.fail_cnt), 15);
                chk("t3_map",   32'(bus.fail_map), 32'hFFF7);
                chk("t3_first", 32'(bus.first_fail_code), 0);
`ifdef DEC_SCAN_SYNDROME_EN
                chk("t3_syn",   32'(bus.syndrome), 32'h0008);
`endif

                run_scan(3, cyc);
                chk("t4_cnt",  32'(bus.fail_cnt), 16);
                chk("t4_map",  32'(bus.fail_map), 32'hFFFF);
                chk("t4_pass", 32'(bus.pass), 0);

                fault = 2; bus.start = 1'b1; step(); bus.start = 1'b0;
                for (int i = 0; i < 10; i++) step();
                rst_n = 1'b0;
                #1;
                chk("t5_busy", 32'(bus.busy), 0);
                chk("t5_sel",  32'(bus.sel), 0);
                chk("t5_cnt",  32'(bus.fail_cnt), 0);
                chk("t5_map",  32'(bus.fail_map), 0);
                step();
                rst_n = 1'b1;
                step();
                run_scan(0, cyc);
                chk("t5_latency", 32'(cyc), 32);
                chk("t5_pass", 32'(bus.pass), 1);

                fault = 3; bus.start = 1'b1; step();
                cyc = 0;
                while (!bus.done && cyc < 200) begin
                    if (cyc == 5) bus.start = 1'b0;
                    step();
                    cyc++;
                end
                bus.start = 1'b0;
                chk("t6_latency", 32'(cyc), 32);
                bus.start = 1'b1; bus.abort = 1'b1;
                step();
                bus.start = 1'b0; bus.abort = 1'b0;
                chk("t6_abort_done", 32'(bus.done), 0);
                chk("t6_abort_busy", 32'(bus.busy), 0);
                chk("t6_abort_cnt",  32'(bus.fail_cnt), 0);
                run_scan(1, cyc);
                run_scan(3, cyc);
                chk("t6_rescan_cnt", 32'(bus.fail_cnt), 16);
                chk("t6_rescan_lat", 32'(cyc), 32);

                for (int k = 0; k < 16; k++) begin
                    case ($urandom_range(3))
                        0:       rnd_tab[k] = 16'h1 << k;
                        1:       rnd_tab[k] = 16'h0000;
                        2:       rnd_tab[k] = (16'h1 << k) | (16'h1 << $urandom_range(15));
                        default: rnd_tab[k] = 16'($urandom);
                    endcase
                end
                for (int i = 0; i < 1500; i++) begin
                    if (m_mode != 1) fault = int'($urandom_range(4));
                    bus.start = ($urandom_range(7) == 0);
                    bus.abort = ($urandom_range(59) == 0);
                    step();
                end
                bus.start = 1'b0; bus.abort = 1'b0;
                step(); step();
            end
            begin
                forever begin
                    @(negedge clk);
                    if (cmp_en) check_model();
                end
            end
        join_any
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
